// File: rtl/spinner_monitor.sv
// Receive-side monitor for an active-low 7-segment spinner bus.
// Decodes hex glyphs, tracks the f-e-d-c-b-a spin, flags step/stall errors.
module spinner_monitor #(
  parameter int unsigned HOLD_MAX   = 100_000_000,
  parameter int unsigned HOLD_W     = 27,
  parameter int unsigned LOCK_STEPS = 2,
  parameter int unsigned LAP_W      = 8,
  parameter int unsigned ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [0:6]       seg_n,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic [2:0]       spin_pos,
  output logic             locked,
  output logic             step_err,
  output logic             stall_err,
  output logic [LAP_W-1:0] lap_count,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned STRK_W = $clog2(LOCK_STEPS + 1);
  localparam logic [STRK_W-1:0] LOCK_LAST =
    STRK_W'(LOCK_STEPS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'(HOLD_MAX - 1);

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

  state_t state_q, state_d;

  logic [0:6]        s, s_q;
  logic              change;
  logic [STRK_W-1:0] streak_q, streak_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [LAP_W-1:0]  lap_d;
  logic [ERR_W-1:0]  err_d;
  logic              step_err_d, stall_err_d;
  logic [3:0]        dig_d;
  logic              dig_ok_d;
  logic              sp_now, sp_prev, step;
  logic [2:0]        pos_now, pos_prev, pos_inc;

  assign s      = ~seg_n;
  assign change = (s != s_q);

  function automatic logic is_spin(input logic [0:6] p);
    return !p[6] && $onehot(p[0:5]);
  endfunction

  function automatic logic [2:0] pos_of(input logic [0:6] p);
    logic [2:0] r;
    r = 3'd0;
    case (1'b1)
      p[5]: r = 3'd0;
      p[4]: r = 3'd1;
      p[3]: r = 3'd2;
      p[2]: r = 3'd3;
      p[1]: r = 3'd4;
      p[0]: r = 3'd5;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

  assign sp_now   = is_spin(s);
  assign sp_prev  = is_spin(s_q);
  assign pos_now  = sp_now ? pos_of(s) : 3'd0;
  assign pos_prev = pos_of(s_q);
  assign pos_inc  = (pos_prev == 3'd5) ? 3'd0 : pos_prev + 3'd1;
  assign step     = sp_now && sp_prev && (pos_now == pos_inc);

  always_comb begin
    dig_d    = 4'd0;
    dig_ok_d = 1'b1;
    case (s)
      7'b1111110: dig_d = 4'h0;
      7'b0110000: dig_d = 4'h1;
      7'b1101101: dig_d = 4'h2;
      7'b1111001: dig_d = 4'h3;
      7'b0110011: dig_d = 4'h4;
      7'b1011011: dig_d = 4'h5;
      7'b1011111: dig_d = 4'h6;
      7'b1110000: dig_d = 4'h7;
      7'b1111111: dig_d = 4'h8;
      7'b1111011: dig_d = 4'h9;
      7'b1110111: dig_d = 4'hA;
      7'b0011111: dig_d = 4'hB;
      7'b1001110: dig_d = 4'hC;
      7'b0111101: dig_d = 4'hD;
      7'b1001111: dig_d = 4'hE;
      7'b1000111: dig_d = 4'hF;
      default: begin
        dig_d    = 4'd0;
        dig_ok_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    hold_d      = hold_q;
    lap_d       = lap_count;
    err_d       = err_count;
    step_err_d  = 1'b0;
    stall_err_d = 1'b0;
    case (state_q)
      HUNT: begin
        if (change) begin
          if (!step) begin
            streak_d = '0;
          end else if (streak_q == LOCK_LAST) begin
            state_d  = LOCKED;
            streak_d = '0;
            hold_d   = '0;
          end else begin
            streak_d = streak_q + 1'b1;
          end
        end
      end
      LOCKED: begin
        // a change on the timeout cycle takes priority over the stall
        if (change && step) begin
          hold_d = '0;
          if (pos_now == 3'd0 && lap_count != '1)
            lap_d = lap_count + 1'b1;
        end else if (change) begin
          step_err_d = 1'b1;
          if (err_count != '1) err_d = err_count + 1'b1;
          state_d  = HUNT;
          streak_d = '0;
          hold_d   = '0;
        end else if (hold_q == HOLD_LAST) begin
          stall_err_d = 1'b1;
          if (err_count != '1) err_d = err_count + 1'b1;
          state_d  = HUNT;
          streak_d = '0;
          hold_d   = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      s_q         <= '0;
      streak_q    <= '0;
      hold_q      <= '0;
      digit       <= '0;
      digit_valid <= 1'b0;
      spin_pos    <= '0;
      locked      <= 1'b0;
      step_err    <= 1'b0;
      stall_err   <= 1'b0;
      lap_count   <= '0;
      err_count   <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s;
      streak_q    <= streak_d;
      hold_q      <= hold_d;
      digit       <= dig_d;
      digit_valid <= dig_ok_d;
      spin_pos    <= pos_now;
      locked      <= (state_d == LOCKED);
      step_err    <= step_err_d;
      stall_err   <= stall_err_d;
      lap_count   <= lap_d;
      err_count   <= err_d;
    end
  end

endmodule

// File: tb/tb_spinner_monitor.sv
// Directed bench for spinner_monitor with HOLD_MAX=8.
// Linear stimulus; immediate assertions count mismatches.
module tb_spinner_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:6] seg_n;
  logic [3:0] digit;
  logic       digit_valid;
  logic [2:0] spin_pos;
  logic       locked;
  logic       step_err;
  logic       stall_err;
  logic [7:0] lap_count;
  logic [7:0] err_count;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [0:6] SF = 7'b1111101;
  localparam logic [0:6] SE = 7'b1111011;
  localparam logic [0:6] SD = 7'b1110111;
  localparam logic [0:6] SC = 7'b1101111;
  localparam logic [0:6] SB = 7'b1011111;
  localparam logic [0:6] SA = 7'b0111111;

  spinner_monitor #(
    .HOLD_MAX  (8),
    .HOLD_W    (4),
    .LOCK_STEPS(2),
    .LAP_W     (8),
    .ERR_W     (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_n      (seg_n),
    .digit      (digit),
    .digit_valid(digit_valid),
    .spin_pos   (spin_pos),
    .locked     (locked),
    .step_err   (step_err),
    .stall_err  (stall_err),
    .lap_count  (lap_count),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [0:6] p, input int n);
    seg_n = p;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    seg_n = 7'b0000000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_digit", digit, 0);
    chk("rst_valid", digit_valid, 0);
    chk("rst_pos", spin_pos, 0);
    chk("rst_locked", locked, 0);
    chk("rst_serr", step_err, 0);
    chk("rst_stall", stall_err, 0);
    chk("rst_lap", lap_count, 0);
    chk("rst_err", err_count, 0);
    rst_n = 1'b1;

    cyc(7'b0000001, 1);
    chk("dec0_digit", digit, 0);
    chk("dec0_valid", digit_valid, 1);
    cyc(7'b1001111, 1);
    chk("dec1_digit", digit, 1);
    chk("dec1_valid", digit_valid, 1);
    cyc(7'b0001000, 1);
    chk("decA_digit", digit, 4'hA);
    cyc(7'b1000010, 1);
    chk("decd_digit", digit, 4'hD);
    cyc(7'b1111110, 1);
    chk("decg_valid", digit_valid, 0);
    chk("decg_digit", digit, 0);
    chk("decg_pos", spin_pos, 0);

    cyc(SF, 3);
    chk("f_locked", locked, 0);
    chk("f_valid", digit_valid, 0);
    cyc(SE, 1);
    chk("e_locked", locked, 0);
    chk("e_pos", spin_pos, 1);
    cyc(SE, 2);
    cyc(SD, 1);
    chk("d_locked", locked, 1);
    chk("d_pos", spin_pos, 2);
    cyc(SD, 2);

    cyc(SC, 3);
    chk("c_pos", spin_pos, 3);
    cyc(SB, 3);
    cyc(SA, 3);
    chk("a_lap", lap_count, 0);
    chk("a_pos", spin_pos, 5);
    cyc(SF, 1);
    chk("f_lap", lap_count, 1);
    chk("lap_errs", err_count, 0);
    chk("lap_locked", locked, 1);
    cyc(SF, 2);

    cyc(SE, 3);
    cyc(SD, 3);
    cyc(SC, 3);
    chk("se_pre_locked", locked, 1);
    chk("se_pre_pos", spin_pos, 3);
    cyc(SA, 1);
    chk("se_pulse", step_err, 1);
    chk("se_cnt", err_count, 1);
    chk("se_locked", locked, 0);
    chk("se_stall", stall_err, 0);
    cyc(SA, 1);
    chk("se_pulse_end", step_err, 0);

    cyc(SF, 1);
    chk("rl_f_locked", locked, 0);
    cyc(SE, 1);
    chk("rl_e_locked", locked, 1);
    cyc(SD, 1);
    cyc(SC, 1);
    cyc(SB, 8);
    chk("b7_stall", stall_err, 0);
    chk("b7_locked", locked, 1);
    cyc(SA, 1);
    chk("race_stall", stall_err, 0);
    chk("race_locked", locked, 1);
    chk("race_lap", lap_count, 1);
    cyc(SA, 7);
    chk("a7_stall", stall_err, 0);
    chk("a7_locked", locked, 1);
    cyc(SA, 1);
    chk("stall_pulse", stall_err, 1);
    chk("stall_cnt", err_count, 2);
    chk("stall_locked", locked, 0);
    chk("stall_serr", step_err, 0);
    cyc(SA, 1);
    chk("stall_end", stall_err, 0);
    cyc(SA, 20);
    chk("hunt_hold", err_count, 2);

    rst_n = 1'b0;
    cyc(SF, 1);
    chk("mid_rst_err", err_count, 0);
    chk("mid_rst_lap", lap_count, 0);
    chk("mid_rst_pos", spin_pos, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
